// File: rtl/ram_port_a_arbiter_if.sv
// Requester-side and RAM port-A bundle for the port-A round-robin arbiter.
// The arbiter connects through the slave modport; requesters and the RAM connect through master.
interface ram_port_a_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 8,
    parameter int NUM_BYTES  = 4,
    parameter int BYTE_WIDTH = 8,
    parameter int DATA_WIDTH = NUM_BYTES * BYTE_WIDTH
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ*NUM_BYTES-1:0]  req_we;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_din;
    logic [NUM_REQ-1:0]            rsp_valid;
    logic [DATA_WIDTH-1:0]         rsp_data;
    logic                          a_re;
    logic [NUM_BYTES-1:0]          a_we;
    logic [ADDR_WIDTH-1:0]         a_addr;
    logic [DATA_WIDTH-1:0]         a_din;
    logic                          a_ready;
    logic [DATA_WIDTH-1:0]         a_dout;

    modport slave (
        input  req_valid, req_we, req_addr, req_din, a_ready, a_dout,
        output req_ready, rsp_valid, rsp_data, a_re, a_we, a_addr, a_din
    );

    modport master (
        output req_valid, req_we, req_addr, req_din, a_ready, a_dout,
        input  req_ready, rsp_valid, rsp_data, a_re, a_we, a_addr, a_din
    );
endinterface

// File: rtl/ram_port_a_arbiter.sv
// Round-robin arbiter sharing UltraRAM port A between NUM_REQ requesters, stalling while
// port B owns the RAM, and tagging accepted reads through the fixed read latency.
module ram_port_a_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int ADDR_WIDTH   = 8,
    parameter int NUM_BYTES    = 4,
    parameter int BYTE_WIDTH   = 8,
    parameter int DATA_WIDTH   = NUM_BYTES * BYTE_WIDTH,
    parameter int READ_LATENCY = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    ram_port_a_arbiter_if.slave  bus
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]      win_idx, cand;
    logic                  win_found, accept, is_read;
    logic [NUM_BYTES-1:0]  win_we;
    logic [ADDR_WIDTH-1:0] win_addr;
    logic [DATA_WIDTH-1:0] win_din;
    logic [NUM_REQ-1:0]    ready_c;

    logic [READ_LATENCY-1:0] tag_vld_q;
    logic [NUM_REQ-1:0]      tag_oh_q [READ_LATENCY];

    // First valid requester at or after rr_ptr, wrapping.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            cand = PTR_W'((int'(rr_ptr_q) + j) % NUM_REQ);
            if (!win_found && bus.req_valid[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    assign win_we   = bus.req_we[int'(win_idx)*NUM_BYTES +: NUM_BYTES];
    assign win_addr = bus.req_addr[int'(win_idx)*ADDR_WIDTH +: ADDR_WIDTH];
    assign win_din  = bus.req_din[int'(win_idx)*DATA_WIDTH +: DATA_WIDTH];
    assign is_read  = (win_we == '0);

    // Reset gates acceptance so nothing is granted while the tags are being cleared.
    assign accept  = win_found & bus.a_ready & rst_n_i;
    assign ready_c = accept ? (NUM_REQ'(1) << win_idx) : '0;

    assign bus.req_ready = ready_c;
    assign bus.a_re      = accept & is_read;
    assign bus.a_we      = accept ? win_we : '0;
    assign bus.a_addr    = win_found ? win_addr : '0;
    assign bus.a_din     = win_found ? win_din : '0;

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (accept) begin
            rr_ptr_d = (int'(win_idx) == NUM_REQ - 1) ? '0 : win_idx + PTR_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rr_ptr_q  <= '0;
            tag_vld_q <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                tag_oh_q[i] <= '0;
            end
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            tag_vld_q[0] <= accept & is_read;
            tag_oh_q[0]  <= ready_c;
            for (int i = 1; i < READ_LATENCY; i++) begin
                tag_vld_q[i] <= tag_vld_q[i-1];
                tag_oh_q[i]  <= tag_oh_q[i-1];
            end
        end
    end

    // RAM output register already aligns the data with the oldest tag.
    assign bus.rsp_valid = tag_vld_q[READ_LATENCY-1] ? tag_oh_q[READ_LATENCY-1] : '0;
    assign bus.rsp_data  = bus.a_dout;
endmodule

// File: tb/tb_ram_port_a_arbiter.sv
// Directed and random checks of the port-A arbiter against a simple port-A RAM model
// (READ_LATENCY=1) plus a READ_LATENCY=3 instance for the reset-in-flight case.
module tb_ram_port_a_arbiter;
    localparam int NR = 4;
    localparam int AW = 8;
    localparam int NB = 4;
    localparam int BW = 8;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst_n;
    logic rst2_n;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    ram_port_a_arbiter_if #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .NUM_BYTES(NB), .BYTE_WIDTH(BW), .DATA_WIDTH(DW)) ifa ();
    ram_port_a_arbiter_if #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .NUM_BYTES(NB), .BYTE_WIDTH(BW), .DATA_WIDTH(DW)) ifb ();

    ram_port_a_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .NUM_BYTES(NB), .BYTE_WIDTH(BW),
                         .DATA_WIDTH(DW), .READ_LATENCY(1)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .bus(ifa));

    ram_port_a_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .NUM_BYTES(NB), .BYTE_WIDTH(BW),
                         .DATA_WIDTH(DW), .READ_LATENCY(3)) dut3 (
        .clk_i(clk), .rst_n_i(rst2_n), .bus(ifb));

    // Port-A RAM model, one output register (READ_LATENCY=1).
    logic [DW-1:0] mem [256];
    logic [DW-1:0] rd_q;
    logic [DW-1:0] wtmp;
    initial for (int i = 0; i < 256; i++) mem[i] = '0;
    always @(posedge clk) begin
        if (ifa.a_we != '0) begin
            wtmp = mem[ifa.a_addr];
            for (int b = 0; b < NB; b++)
                if (ifa.a_we[b]) wtmp[b*BW +: BW] = ifa.a_din[b*BW +: BW];
            mem[ifa.a_addr] <= wtmp;
        end
        if (ifa.a_re) rd_q <= mem[ifa.a_addr];
    end
    assign ifa.a_dout = rd_q;
    assign ifb.a_ready = 1'b1;
    assign ifb.a_dout  = '0;

    task automatic clr_a();
        ifa.req_valid = '0; ifa.req_we = '0; ifa.req_addr = '0; ifa.req_din = '0;
    endtask

    task automatic put_a(input int i, input logic [NB-1:0] we, input logic [AW-1:0] addr, input logic [DW-1:0] din);
        ifa.req_valid[i] = 1'b1;
        ifa.req_we[i*NB +: NB] = we;
        ifa.req_addr[i*AW +: AW] = addr;
        ifa.req_din[i*DW +: DW] = din;
    endtask

    task automatic clr_b();
        ifb.req_valid = '0; ifb.req_we = '0; ifb.req_addr = '0; ifb.req_din = '0;
    endtask

    task automatic put_b(input int i, input logic [AW-1:0] addr);
        ifb.req_valid[i] = 1'b1;
        ifb.req_addr[i*AW +: AW] = addr;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rst2_n = 1'b0; ifa.a_ready = 1'b1;
        clr_a(); clr_b();
        put_a(0, 4'h0, 8'h10, '0);
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        checks++; if (ifa.req_ready !== 4'b0000) begin errors++; $display("FAIL rst_ready: got %b exp 0000", ifa.req_ready); end
        checks++; if (ifa.a_re !== 1'b0 || ifa.a_we !== 4'h0) begin errors++; $display("FAIL rst_en: got re=%b we=%h exp 0/0", ifa.a_re, ifa.a_we); end
        checks++; if (ifa.rsp_valid !== 4'b0000) begin errors++; $display("FAIL rst_rsp: got %b exp 0000", ifa.rsp_valid); end
        checks++; if (ifb.rsp_valid !== 4'b0000) begin errors++; $display("FAIL rst_rsp3: got %b exp 0000", ifb.rsp_valid); end
        clr_a();
        rst_n = 1'b1; rst2_n = 1'b1;
    endtask

    task automatic test_write_read();
        @(negedge clk); clr_a(); put_a(2, 4'hF, 8'h10, 32'hDEADBEEF); #1;
        checks++; if (ifa.req_ready !== 4'b0100) begin errors++; $display("FAIL wr_ready: got %b exp 0100", ifa.req_ready); end
        checks++; if (ifa.a_we !== 4'hF || ifa.a_re !== 1'b0) begin errors++; $display("FAIL wr_en: got we=%h re=%b exp f/0", ifa.a_we, ifa.a_re); end
        checks++; if (ifa.a_addr !== 8'h10 || ifa.a_din !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_bus: got %h/%h exp 10/deadbeef", ifa.a_addr, ifa.a_din); end
        @(negedge clk); clr_a(); put_a(0, 4'h0, 8'h10, '0); #1;
        checks++; if (ifa.rsp_valid !== 4'b0000) begin errors++; $display("FAIL wr_norsp: got %b exp 0000", ifa.rsp_valid); end
        checks++; if (ifa.req_ready !== 4'b0001 || ifa.a_re !== 1'b1) begin errors++; $display("FAIL rd_ready: got %b re=%b exp 0001 re=1", ifa.req_ready, ifa.a_re); end
        @(negedge clk); clr_a(); #1;
        checks++; if (ifa.rsp_valid !== 4'b0001) begin errors++; $display("FAIL rd_rsp: got %b exp 0001", ifa.rsp_valid); end
        checks++; if (ifa.rsp_data !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data: got %h exp deadbeef", ifa.rsp_data); end
        @(negedge clk); #1;
        checks++; if (ifa.rsp_valid !== 4'b0000) begin errors++; $display("FAIL rd_once: got %b exp 0000", ifa.rsp_valid); end
    endtask

    task automatic test_byte_mask();
        @(negedge clk); clr_a(); put_a(0, 4'hF, 8'h03, 32'h11223344); #1;
        checks++; if (ifa.req_ready !== 4'b0001) begin errors++; $display("FAIL bm_w1: got %b exp 0001", ifa.req_ready); end
        @(negedge clk); clr_a(); put_a(0, 4'b0101, 8'h03, 32'hAABBCCDD); #1;
        checks++; if (ifa.a_we !== 4'b0101) begin errors++; $display("FAIL bm_we: got %b exp 0101", ifa.a_we); end
        @(negedge clk); clr_a(); put_a(0, 4'h0, 8'h03, '0); #1;
        checks++; if (ifa.a_re !== 1'b1) begin errors++; $display("FAIL bm_re: got %b exp 1", ifa.a_re); end
        @(negedge clk); clr_a(); #1;
        checks++; if (ifa.rsp_valid !== 4'b0001 || ifa.rsp_data !== 32'h11BB33DD) begin errors++; $display("FAIL bm_data: got %b/%h exp 0001/11bb33dd", ifa.rsp_valid, ifa.rsp_data); end
    endtask

    task automatic test_round_robin();
        logic [NR-1:0] pend;
        logic [NR-1:0] oh;
        for (int i = 0; i < NR; i++) begin
            @(negedge clk); clr_a(); put_a(3, 4'hF, AW'(i), 32'hA0A00000 + DW'(i)); #1;
            checks++; if (ifa.req_ready !== 4'b1000) begin errors++; $display("FAIL rr_pre%0d: got %b exp 1000", i, ifa.req_ready); end
        end
        pend = 4'b1111;
        for (int c = 0; c <= NR; c++) begin
            @(negedge clk); clr_a();
            for (int i = 0; i < NR; i++) if (pend[i]) put_a(i, 4'h0, AW'(i), '0);
            #1;
            if (c < NR) begin
                oh = 4'b0001 << c;
                checks++; if (ifa.req_ready !== oh) begin errors++; $display("FAIL rr_grant%0d: got %b exp %b", c, ifa.req_ready, oh); end
                pend[c] = 1'b0;
            end
            if (c > 0) begin
                oh = 4'b0001 << (c - 1);
                checks++; if (ifa.rsp_valid !== oh || ifa.rsp_data !== 32'hA0A00000 + DW'(c - 1)) begin
                    errors++; $display("FAIL rr_rsp%0d: got %b/%h exp %b/%h", c, ifa.rsp_valid, ifa.rsp_data, oh, 32'hA0A00000 + DW'(c - 1));
                end
            end
        end
    endtask

    task automatic test_stall();
        @(negedge clk); clr_a(); put_a(0, 4'hF, 8'h20, 32'h5); #1;
        checks++; if (ifa.req_ready !== 4'b0001) begin errors++; $display("FAIL st_pre: got %b exp 0001", ifa.req_ready); end
        ifa.a_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            @(negedge clk); clr_a(); put_a(1, 4'h0, 8'h01, '0); put_a(3, 4'h0, 8'h03, '0); #1;
            checks++; if (ifa.req_ready !== 4'b0000 || ifa.a_re !== 1'b0 || ifa.a_we !== 4'h0) begin
                errors++; $display("FAIL st_stall%0d: got rdy=%b re=%b we=%h exp 0000/0/0", s, ifa.req_ready, ifa.a_re, ifa.a_we);
            end
        end
        @(negedge clk); ifa.a_ready = 1'b1; clr_a(); put_a(1, 4'h0, 8'h01, '0); put_a(3, 4'h0, 8'h03, '0); #1;
        checks++; if (ifa.req_ready !== 4'b0010 || ifa.a_addr !== 8'h01) begin errors++; $display("FAIL st_g1: got %b/%h exp 0010/01", ifa.req_ready, ifa.a_addr); end
        @(negedge clk); clr_a(); put_a(3, 4'h0, 8'h03, '0); #1;
        checks++; if (ifa.req_ready !== 4'b1000) begin errors++; $display("FAIL st_g3: got %b exp 1000", ifa.req_ready); end
        checks++; if (ifa.rsp_valid !== 4'b0010 || ifa.rsp_data !== 32'hA0A00001) begin errors++; $display("FAIL st_r1: got %b/%h exp 0010/a0a00001", ifa.rsp_valid, ifa.rsp_data); end
        @(negedge clk); clr_a(); #1;
        checks++; if (ifa.rsp_valid !== 4'b1000 || ifa.rsp_data !== 32'hA0A00003) begin errors++; $display("FAIL st_r3: got %b/%h exp 1000/a0a00003", ifa.rsp_valid, ifa.rsp_data); end
    endtask

    task automatic test_reset_midflight();
        logic [NR-1:0] oh;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); clr_b(); put_b(i, AW'(i)); #1;
            oh = 4'b0001 << i;
            checks++; if (ifb.req_ready !== oh) begin errors++; $display("FAIL mf_grant%0d: got %b exp %b", i, ifb.req_ready, oh); end
        end
        #1; rst2_n = 1'b0; clr_b(); #1;
        checks++; if (ifb.rsp_valid !== 4'b0000 || ifb.req_ready !== 4'b0000) begin errors++; $display("FAIL mf_inrst: got %b/%b exp 0000/0000", ifb.rsp_valid, ifb.req_ready); end
        @(negedge clk); rst2_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk); #1;
            checks++; if (ifb.rsp_valid !== 4'b0000) begin errors++; $display("FAIL mf_quiet%0d: got %b exp 0000", c, ifb.rsp_valid); end
        end
        @(negedge clk); for (int i = 0; i < NR; i++) put_b(i, AW'(i)); #1;
        checks++; if (ifb.req_ready !== 4'b0001) begin errors++; $display("FAIL mf_ptr: got %b exp 0001", ifb.req_ready); end
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk); clr_b(); #1;
            oh = (c == 3) ? 4'b0001 : 4'b0000;
            checks++; if (ifb.rsp_valid !== oh) begin errors++; $display("FAIL mf_lat%0d: got %b exp %b", c, ifb.rsp_valid, oh); end
        end
    endtask

    task automatic test_random();
        logic [DW-1:0] sb [8];
        logic [NR-1:0] pend;
        logic [NB-1:0] p_we [NR];
        logic [AW-1:0] p_addr [NR];
        logic [DW-1:0] p_din [NR];
        int            wait_cnt [NR];
        logic [NR-1:0] exp_oh, exp_ready;
        logic [DW-1:0] exp_d;
        int            rr_m, k, idx;
        for (int i = 0; i < 8; i++) sb[i] = (i < 4) ? 32'hA0A00000 + DW'(i) : '0;
        pend = '0; exp_oh = '0; exp_d = '0; rr_m = 0;
        for (int i = 0; i < NR; i++) wait_cnt[i] = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            ifa.a_ready = ($urandom_range(3) != 0);
            for (int i = 0; i < NR; i++) begin
                if (!pend[i] && $urandom_range(1) == 1) begin
                    pend[i]     = 1'b1;
                    p_addr[i]   = AW'($urandom_range(7));
                    p_we[i]     = ($urandom_range(1) == 1) ? NB'($urandom_range(15)) : '0;
                    p_din[i]    = $urandom;
                    wait_cnt[i] = 0;
                end
            end
            clr_a();
            for (int i = 0; i < NR; i++) if (pend[i]) put_a(i, p_we[i], p_addr[i], p_din[i]);
            #1;
            k = -1;
            for (int j = 0; j < NR; j++) begin
                idx = (rr_m + j) % NR;
                if (k < 0 && pend[idx]) k = idx;
            end
            exp_ready = (k >= 0 && ifa.a_ready) ? (4'b0001 << k) : 4'b0000;
            checks++; if (ifa.req_ready !== exp_ready) begin errors++; $display("FAIL rnd_grant c%0d: got %b exp %b", cyc, ifa.req_ready, exp_ready); end
            checks++; if (ifa.rsp_valid !== exp_oh) begin errors++; $display("FAIL rnd_rspv c%0d: got %b exp %b", cyc, ifa.rsp_valid, exp_oh); end
            if (exp_oh != '0) begin
                checks++; if (ifa.rsp_data !== exp_d) begin errors++; $display("FAIL rnd_data c%0d: got %h exp %h", cyc, ifa.rsp_data, exp_d); end
            end
            exp_oh = '0;
            if (exp_ready != '0) begin
                checks++; if (wait_cnt[k] >= NR) begin errors++; $display("FAIL rnd_wait c%0d: got %0d exp <%0d", cyc, wait_cnt[k], NR); end
                for (int j = 0; j < NR; j++) if (j != k && pend[j]) wait_cnt[j]++;
                if (p_we[k] == '0) begin
                    exp_oh = exp_ready;
                    exp_d  = sb[p_addr[k][2:0]];
                    checks++; if (ifa.a_re !== 1'b1 || ifa.a_addr !== p_addr[k]) begin errors++; $display("FAIL rnd_rd c%0d: got re=%b a=%h exp 1/%h", cyc, ifa.a_re, ifa.a_addr, p_addr[k]); end
                end else begin
                    for (int b = 0; b < NB; b++)
                        if (p_we[k][b]) sb[p_addr[k][2:0]][b*BW +: BW] = p_din[k][b*BW +: BW];
                    checks++; if (ifa.a_we !== p_we[k] || ifa.a_re !== 1'b0) begin errors++; $display("FAIL rnd_wr c%0d: got we=%h re=%b exp %h/0", cyc, ifa.a_we, ifa.a_re, p_we[k]); end
                end
                pend[k] = 1'b0;
                rr_m = (k + 1) % NR;
            end
        end
        @(negedge clk); clr_a(); ifa.a_ready = 1'b1; #1;
        checks++; if (ifa.rsp_valid !== exp_oh) begin errors++; $display("FAIL rnd_drain: got %b exp %b", ifa.rsp_valid, exp_oh); end
        if (exp_oh != '0) begin
            checks++; if (ifa.rsp_data !== exp_d) begin errors++; $display("FAIL rnd_drain_data: got %h exp %h", ifa.rsp_data, exp_d); end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_byte_mask();
        test_round_robin();
        test_stall();
        test_reset_midflight();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
